// File: rtl/vend_credit_ctrl.sv
// Purpose : vending credit/sequencing controller; accumulates half-unit coin credit,
//           arbitrates selection vs refund, then drives the dispenser and change-hopper handshakes.
// Latency : every response (credit update, pulses, req levels) is registered and visible one cycle after the causing input.
// Backpr. : no stalls; coins that cannot be taken are answered with coin_reject, and requests are held until their ack.
//
// Ports   : sys_clk/sys_rst_n      clock, async active-low reset
//           pHalf/pOne             coin pulses (0.5 / 1.0)
//           sel_vld/sel_id/refund  front-panel buttons
//           disp_req/disp_id/disp_ack   dispenser handshake
//           chg_req/chg_coin/chg_ack    hopper handshake, one coin per ack
//           credit, coin_reject, sel_deny, busy   status outputs
// Option  : define VEND_TIMEOUT_REFUND_EN to build the idle auto-refund (TIMEOUT_CYCLES idle cycles in CREDIT).

module vend_credit_ctrl #(
  parameter int MAX_CREDIT     = 8,
  parameter int PRICE0         = 3,
  parameter int PRICE1         = 4,
  parameter int PRICE2         = 5,
  parameter int PRICE3         = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pHalf,
  input  logic       pOne,
  input  logic       sel_vld,
  input  logic [1:0] sel_id,
  input  logic       refund,
  input  logic       disp_ack,
  input  logic       chg_ack,
  output logic [3:0] credit,
  output logic       coin_reject,
  output logic       sel_deny,
  output logic       disp_req,
  output logic [1:0] disp_id,
  output logic       chg_req,
  output logic       chg_coin,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'b0001,
    S_CREDIT   = 4'b0010,
    S_DISPENSE = 4'b0100,
    S_CHANGE   = 4'b1000
  } state_t;

  state_t state;

  function automatic logic [3:0] price_of(input logic [1:0] id);
    case (id)
      2'd0:    price_of = 4'(PRICE0);
      2'd1:    price_of = 4'(PRICE1);
      2'd2:    price_of = 4'(PRICE2);
      default: price_of = 4'(PRICE3);
    endcase
  endfunction

  logic       coin_any;
  logic       coin_bad;
  logic [4:0] credit_sum;
  logic       coin_fits;
  logic       coin_accept;
  logic [3:0] sel_price;
  logic [3:0] disp_rem;
  logic [3:0] chg_rem;
  logic       timeout_fire;

  assign coin_any    = pHalf | pOne;
  assign coin_bad    = pHalf & pOne;
  // One bit of headroom so an overflowing sum is caught instead of wrapping.
  assign credit_sum  = {1'b0, credit} + (pOne ? 5'd2 : 5'd1);
  assign coin_fits   = (credit_sum <= 5'(MAX_CREDIT));
  assign coin_accept = coin_any & ~coin_bad & coin_fits & ~refund & ~sel_vld;
  assign sel_price   = price_of(sel_id);
  // The price check before DISPENSE guarantees these never underflow.
  assign disp_rem    = credit - price_of(disp_id);
  assign chg_rem     = credit - (chg_coin ? 4'd2 : 4'd1);

`ifdef VEND_TIMEOUT_REFUND_EN
  logic [15:0] idle_cnt;

  // Counts quiet cycles in CREDIT; any accepted coin, button press or leaving CREDIT restarts it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_cnt <= '0;
    end else if (state != S_CREDIT || refund || sel_vld || coin_accept || timeout_fire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign timeout_fire = (state == S_CREDIT) && !refund && !sel_vld && !coin_accept &&
                        (idle_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  // The timeout length only matters when the auto-refund is built.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign timeout_fire   = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      credit      <= '0;
      coin_reject <= 1'b0;
      sel_deny    <= 1'b0;
      disp_req    <= 1'b0;
      disp_id     <= '0;
      chg_req     <= 1'b0;
      chg_coin    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      sel_deny    <= 1'b0;
      case (state)
        S_IDLE, S_CREDIT: begin
          if (refund || timeout_fire) begin
            // A coin colliding with a button is never credited.
            coin_reject <= coin_any;
            // IDLE holds no credit, so refund there is a no-op.
            if (state == S_CREDIT) begin
              state    <= S_CHANGE;
              chg_req  <= 1'b1;
              chg_coin <= (credit >= 4'd2);
              busy     <= 1'b1;
            end
          end else if (sel_vld) begin
            coin_reject <= coin_any;
            if (state == S_CREDIT) begin
              if (credit >= sel_price) begin
                state    <= S_DISPENSE;
                disp_req <= 1'b1;
                disp_id  <= sel_id;
                busy     <= 1'b1;
              end else begin
                sel_deny <= 1'b1;
              end
            end
          end else if (coin_any) begin
            if (coin_accept) begin
              credit <= credit_sum[3:0];
              state  <= S_CREDIT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end

        S_DISPENSE: begin
          coin_reject <= coin_any;
          if (disp_ack) begin
            disp_req <= 1'b0;
            credit   <= disp_rem;
            if (disp_rem != 4'd0) begin
              state    <= S_CHANGE;
              chg_req  <= 1'b1;
              chg_coin <= (disp_rem >= 4'd2);
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        S_CHANGE: begin
          coin_reject <= coin_any;
          if (chg_ack) begin
            credit <= chg_rem;
            if (chg_rem == 4'd0) begin
              state    <= S_IDLE;
              chg_req  <= 1'b0;
              chg_coin <= 1'b0;
              busy     <= 1'b0;
            end else begin
              chg_coin <= (chg_rem >= 4'd2);
            end
          end
        end

        default: begin
          // Corrupted one-hot state: fall back to a clean, empty IDLE.
          state    <= S_IDLE;
          credit   <= '0;
          disp_req <= 1'b0;
          chg_req  <= 1'b0;
          chg_coin <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vend_credit_ctrl.md
Name: vend_credit_ctrl

Overview:
- Sequencing controller for the vending datapath. Accumulates coin credit in half-unit steps and arbitrates between selection and refund requests.
- Drives a req/ack handshake to the product dispenser, then pays out change through a coin-hopper handshake.
- Sits between the coin acceptor / front-panel buttons and the dispenser and hopper actuators.

Parameters:
- MAX_CREDIT, 8, credit ceiling in half-units (8 = 4.0); coins that would exceed it are rejected.
- PRICE0, 3, price of product 0 in half-units.
- PRICE1, 4, price of product 1 in half-units.
- PRICE2, 5, price of product 2 in half-units.
- PRICE3, 6, price of product 3 in half-units.
- TIMEOUT_CYCLES, 1000, idle cycles in CREDIT before auto-refund (used only with the optional feature).

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- pHalf  in  1  one-cycle pulse: 0.5 coin inserted.
- pOne  in  1  one-cycle pulse: 1.0 coin inserted.
- sel_vld  in  1  one-cycle pulse: product selected.
- sel_id  in  2  product index, qualified by sel_vld.
- refund  in  1  one-cycle pulse: refund button.
- disp_ack  in  1  dispenser done; single-cycle pulse.
- chg_ack  in  1  hopper ejected one coin; single-cycle pulse.
- credit  out  4  current credit in half-units, registered.
- coin_reject  out  1  one-cycle pulse: coin returned uncredited.
- sel_deny  out  1  one-cycle pulse: selection refused.
- disp_req  out  1  held high until disp_ack.
- disp_id  out  2  product being dispensed; valid while disp_req is high.
- chg_req  out  1  held high while change is owed.
- chg_coin  out  1  coin type requested: 1 = 1.0 coin, 0 = 0.5 coin.
- busy  out  1  high in DISPENSE or CHANGE.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE and credit to 0.
  - All outputs go to 0.
  - Owed change is discarded.
- States: IDLE, CREDIT, DISPENSE, CHANGE. One-hot encoded; illegal encodings go to IDLE.
- Event priority per cycle in IDLE/CREDIT: refund > sel_vld > coin.
  - A coin arriving in the same cycle as refund or sel_vld is rejected: coin_reject pulses and credit is unchanged.
- Coins are accepted only in IDLE and CREDIT; in DISPENSE and CHANGE every coin pulse gives coin_reject.
- pHalf and pOne high in the same cycle: rejected as invalid; coin_reject pulses once and credit is unchanged.
- Accepted coin: credit += 1 (pHalf) or += 2 (pOne), visible on credit the next cycle.
  - If the new credit would exceed MAX_CREDIT, the coin is rejected and credit holds.
  - Next state is CREDIT.
- IDLE: refund and sel_vld are ignored, with no sel_deny.
- CREDIT, sel_vld:
  - price = PRICE[sel_id].
  - If credit >= price: go to DISPENSE next cycle; disp_req=1 and disp_id=sel_id, registered.
  - Otherwise sel_deny pulses next cycle and the state stays CREDIT.
- CREDIT, refund: go to CHANGE with the full credit owed.
- DISPENSE:
  - disp_req is held until the cycle in which disp_ack=1.
  - In the next cycle: disp_req=0 and credit -= price. Go to CHANGE if the remainder is > 0, else IDLE.
  - sel_vld and refund are ignored; no timeout applies.
- CHANGE:
  - chg_req=1.
  - chg_coin=1 if credit >= 2, else 0.
  - On chg_ack, credit decreases by 2 or 1 to match the chg_coin value in that cycle.
  - When credit reaches 0: chg_req=0, next state IDLE.
  - Inputs other than chg_ack are ignored, and coins are rejected.
- Credit arithmetic:
  - 4-bit unsigned; never wraps.
  - The subtraction is guaranteed non-negative by the price check.
- An ack arriving with no req outstanding is ignored.

Optional Feature:
- Macro: VEND_TIMEOUT_REFUND_EN.
- Defined:
  - A 16-bit idle counter runs in CREDIT. It clears on any accepted coin, sel_vld or refund, and on entering CREDIT.
  - On reaching TIMEOUT_CYCLES the controller goes to CHANGE and refunds the full credit, exactly as a refund press.
- Undefined:
  - No counter is built.
  - CREDIT persists indefinitely.

Test Plan:
1. Reset, pOne, pOne, pHalf, then sel_vld with sel_id=1 (price 4) -> credit shows 2, 4, 5. Then disp_req=1 with disp_id=1 until disp_ack. Then chg_req with chg_coin=0, one chg_ack, credit=0, state IDLE.
2. Credit 2, sel_vld with sel_id=3 (price 6) -> sel_deny pulses for 1 cycle, credit stays 2, disp_req stays 0.
3. Credit 7, then pOne -> coin_reject and credit stays 7. Then pHalf -> credit 8. Then pHalf and pOne in the same cycle -> coin_reject.
4. Credit 5, refund -> chg_coin sequence 1, 1, 0 across three chg_acks; credit goes 5→3→1→0; chg_req drops and busy drops.
5. pHalf during DISPENSE, plus sel_vld+pOne together in CREDIT -> coin_reject both times, and the selection is processed. Assert sys_rst_n low mid-CHANGE -> credit=0, chg_req=0, IDLE immediately.
6. With VEND_TIMEOUT_REFUND_EN and TIMEOUT_CYCLES=10: credit 3 with no activity -> CHANGE entered after 10 cycles, refund 1.0 then 0.5. Without the macro: still CREDIT after 20 cycles.
